// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bnn_pkg
//  Brief    : Shared constants and packer state encoding for the BNN front end.
//  Revision : 1.0
// ============================================================================
package bnn_pkg;

    localparam int N_PIX   = 784;
    localparam int N_CLASS = 10;
    localparam int RES_W   = 4;
    localparam int IDX_W   = $clog2(N_PIX);
    localparam int FRAME_W = 16;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } pk_state_e;

endpackage
`default_nettype wire

// File: rtl/bnn_img_packer.sv
`default_nettype none
// ============================================================================
//  Module   : bnn_img_packer
//  Brief    : Binarizes a 28x28 pixel stream, hands the packed image to the BNN
//             core and returns its class. Optional WAIT timeout is enabled by
//             defining BNN_PACKER_TIMEOUT_EN.
//  Revision : 1.0
// ============================================================================
module bnn_img_packer
    import bnn_pkg::*;
#(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned BIN_THR = 128,
    parameter int unsigned TIMEOUT = 4096
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [PIX_W-1:0]   s_pixel,
    input  logic               s_last,
    output logic               m_valid,
    output logic [N_PIX-1:0]   m_data,
    input  logic               bnn_valid,
    input  logic [RES_W-1:0]   bnn_result,
    output logic               r_valid,
    input  logic               r_ready,
    output logic [RES_W-1:0]   r_result,
    output logic [FRAME_W-1:0] r_frame,
    output logic               err
);

    pk_state_e            state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_PIX-1:0]     m_data_q, m_data_d;
    logic [RES_W-1:0]     r_result_q, r_result_d;
    logic [FRAME_W-1:0]   r_frame_q, r_frame_d;
    logic                 err_q, err_d;

    logic                 w_pix_bit;
    logic                 w_idx_last;
    logic [IDX_W-1:0]     w_bitpos;
    logic                 w_tmo_hit;

    // Widen before comparing so a threshold above the pixel range is honoured.
    assign w_pix_bit  = (32'(s_pixel) >= 32'(BIN_THR));
    assign w_idx_last = (idx_q == IDX_W'(N_PIX - 1));
    assign w_bitpos   = IDX_W'(N_PIX - 1) - idx_q;

`ifdef BNN_PACKER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign w_tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

    // Held at zero outside WAIT so every WAIT visit starts a fresh count.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == ST_WAIT) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    localparam int unsigned c_unused_timeout = TIMEOUT;

    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FILL;
            idx_q      <= '0;
            m_data_q   <= '0;
            r_result_q <= '0;
            r_frame_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            m_data_q   <= m_data_d;
            r_result_q <= r_result_d;
            r_frame_q  <= r_frame_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        m_data_d   = m_data_q;
        r_result_d = r_result_q;
        r_frame_d  = r_frame_q;
        err_d      = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (s_valid) begin
                    // s_last must coincide exactly with the final pixel.
                    if (s_last != w_idx_last) begin
                        err_d    = 1'b1;
                        m_data_d = '0;
                        idx_d    = '0;
                    end else begin
                        m_data_d[w_bitpos] = w_pix_bit;
                        if (w_idx_last) begin
                            idx_d   = '0;
                            state_d = ST_ISSUE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bnn_valid) begin
                    r_result_d = bnn_result;
                    r_frame_d  = r_frame_q + 1'b1;
                    state_d    = ST_RESP;
                end else if (w_tmo_hit) begin
                    err_d    = 1'b1;
                    m_data_d = '0;
                    state_d  = ST_FILL;
                end
            end
            ST_RESP: begin
                if (r_ready) begin
                    m_data_d = '0;
                    state_d  = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    assign s_ready  = (state_q == ST_FILL);
    assign m_valid  = (state_q == ST_ISSUE);
    assign r_valid  = (state_q == ST_RESP);
    assign m_data   = m_data_q;
    assign r_result = r_result_q;
    assign r_frame  = r_frame_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bnn_img_packer.sv
`default_nettype none
// Randomized scoreboard bench for bnn_img_packer; expected images and results
// are derived from pixel values and the frame count, never from the DUT.
module tb_bnn_img_packer;
    import bnn_pkg::*;

    localparam int PIX_W   = 8;
    localparam int BIN_THR = 128;
`ifdef BNN_PACKER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 4096;
`endif
    localparam int MAX_DELAY = (TB_TIMEOUT > 43) ? 40 : TB_TIMEOUT - 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid;
    logic               s_ready;
    logic [PIX_W-1:0]   s_pixel;
    logic               s_last;
    logic               m_valid;
    logic [N_PIX-1:0]   m_data;
    logic               bnn_valid;
    logic [RES_W-1:0]   bnn_result;
    logic               r_valid;
    logic               r_ready;
    logic [RES_W-1:0]   r_result;
    logic [15:0]        r_frame;
    logic               err;

    always #5 clk = ~clk;

    bnn_img_packer #(
        .PIX_W   (PIX_W),
        .BIN_THR (BIN_THR),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_pixel    (s_pixel),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .bnn_valid  (bnn_valid),
        .bnn_result (bnn_result),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_result   (r_result),
        .r_frame    (r_frame),
        .err        (err)
    );

    int               checks = 0;
    int               errors = 0;
    logic [N_PIX-1:0] q_frame[$];
    logic [19:0]      q_res[$];
    int               err_pending = 0;
    int               rvalid_seen = 0;
    logic [15:0]      model_frames = '0;
    logic [N_PIX-1:0] last_md = '0;
    logic [N_PIX-1:0] mon_md;
    logic [19:0]      mon_res;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an output.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (m_valid) begin
                if (q_frame.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m_valid_unexpected: got m_valid=1 expected 0");
                end else begin
                    mon_md = q_frame.pop_front();
                    checks++;
                    if (m_data !== mon_md) begin
                        errors++;
                        $display("FAIL m_data: got %h expected %h", m_data, mon_md);
                    end
                end
            end
            if (r_valid) rvalid_seen++;
            if (r_valid && r_ready) begin
                if (q_res.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_valid_unexpected: got r_valid=1 expected 0");
                end else begin
                    mon_res = q_res.pop_front();
                    chk("r_result", 64'(r_result), 64'(mon_res[19:16]));
                    chk("r_frame", 64'(r_frame), 64'(mon_res[15:0]));
                end
            end
            if (err) begin
                checks++;
                if (err_pending == 0) begin
                    errors++;
                    $display("FAIL err_unexpected: got err=1 expected 0");
                end else begin
                    err_pending--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!s_ready && n < 2000) begin tick(); n++; end
        if (!s_ready) begin
            checks++; errors++;
            $display("FAIL s_ready_timeout: got 0 expected 1");
        end
    endtask

    // bad_at < 0: clean frame; 0..782: s_last early there; 783: s_last withheld.
    task automatic send_frame(input int mode, input int bad_at, input int gap_pct);
        logic [PIX_W-1:0] pix;
        logic [N_PIX-1:0] exp_md;
        int last_idx;
        exp_md   = '0;
        last_idx = (bad_at >= 0 && bad_at < N_PIX - 1) ? bad_at : N_PIX - 1;
        for (int i = 0; i <= last_idx; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                s_valid = 1'b0;
                s_pixel = PIX_W'($urandom);
                tick();
            end
            case (mode)
                1:       pix = (i % 2 == 0) ? 8'd200 : 8'd50;
                2:       pix = (i % 3 == 0) ? 8'd127 : 8'd128;
                3:       pix = 8'd0;
                4:       pix = 8'd255;
                default: pix = PIX_W'($urandom);
            endcase
            exp_md[N_PIX-1-i] = (int'(pix) >= BIN_THR);
            s_valid = 1'b1;
            s_pixel = pix;
            if (bad_at < 0)             s_last = (i == N_PIX - 1);
            else if (bad_at < N_PIX-1)  s_last = (i == bad_at);
            else                        s_last = 1'b0;
            wait_ready();
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (bad_at < 0) begin
            q_frame.push_back(exp_md);
            last_md = exp_md;
            chk("m_valid_latency", 64'(m_valid), 64'd1);
        end else begin
            err_pending++;
        end
    endtask

    // Entered in the ISSUE cycle; optionally pulses bnn_valid there first.
    task automatic bnn_respond(input logic [3:0] res, input int delay, input bit issue_pulse);
        bnn_valid = issue_pulse;
        tick();
        bnn_valid = 1'b0;
        repeat (delay) tick();
        bnn_valid    = 1'b1;
        bnn_result   = res;
        model_frames = model_frames + 16'd1;
        q_res.push_back({res, model_frames});
        tick();
        bnn_valid  = 1'b0;
        bnn_result = RES_W'($urandom);
    endtask

    task automatic consume(input int hold, input logic [3:0] res);
        int n = 0;
        r_ready = 1'b0;
        while (!r_valid && n < 100) begin tick(); n++; end
        chk("r_valid_wait", 64'(r_valid), 64'd1);
        for (int k = 0; k < hold; k++) begin
            chk("r_valid_hold", 64'(r_valid), 64'd1);
            chk("r_result_hold", 64'(r_result), 64'(res));
            chk("r_frame_hold", 64'(r_frame), 64'(model_frames));
            chk("m_data_hold", 64'(m_data === last_md), 64'd1);
            tick();
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        chk("r_valid_drop", 64'(r_valid), 64'd0);
        chk("s_ready_after", 64'(s_ready), 64'd1);
        chk("m_data_cleared", 64'(|m_data), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N_PIX-1:0] pat;
        logic [3:0]       res;
        int               seen;

        rst = 1'b1; s_valid = 1'b0; s_pixel = '0; s_last = 1'b0;
        bnn_valid = 1'b0; bnn_result = '0; r_ready = 1'b0;
        repeat (3) tick();
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(|m_data), 64'd0);
        chk("rst_r_valid", 64'(r_valid), 64'd0);
        chk("rst_r_result", 64'(r_result), 64'd0);
        chk("rst_r_frame", 64'(r_frame), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        chk("s_ready_after_rst", 64'(s_ready), 64'd1);

        // Alternating 200/50 image, bnn_valid also pulsed during ISSUE.
        send_frame(1, -1, 0);
        pat = {392{2'b10}};
        chk("alt_pattern", 64'(m_data === pat), 64'd1);
        bnn_respond(4'd7, 3, 1'b1);
        consume(5, 4'd7);
        chk("first_frame_count", 64'(r_frame), 64'd1);

        // bnn_valid while filling is ignored.
        seen = rvalid_seen;
        bnn_valid = 1'b1; tick(); tick(); bnn_valid = 1'b0;
        repeat (3) tick();
        chk("fill_bnn_no_rvalid", 64'(rvalid_seen - seen), 64'd0);
        chk("fill_bnn_frame", 64'(r_frame), 64'(model_frames));

        // Framing errors: early s_last, then missing s_last.
        send_frame(0, 500, 10);
        repeat (2) tick();
        send_frame(0, 783, 0);
        repeat (2) tick();
        send_frame(0, -1, 15);
        res = RES_W'($urandom_range(9));
        bnn_respond(res, 2, 1'b0);
        consume(1, res);

        // Threshold edges and random images with random gaps and latencies.
        for (int f = 0; f < 6; f++) begin
            send_frame((f < 3) ? f + 2 : 0, -1, int'($urandom_range(30)));
            res = RES_W'($urandom_range(9));
            bnn_respond(res, int'($urandom_range(MAX_DELAY)), 1'($urandom));
            consume(int'($urandom_range(4)), res);
        end

        // Reset while waiting on the core, then a stale bnn_valid.
        send_frame(0, -1, 0);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("wrst_m_valid", 64'(m_valid), 64'd0);
        chk("wrst_m_data", 64'(|m_data), 64'd0);
        chk("wrst_r_valid", 64'(r_valid), 64'd0);
        chk("wrst_r_result", 64'(r_result), 64'd0);
        chk("wrst_r_frame", 64'(r_frame), 64'd0);
        chk("wrst_err", 64'(err), 64'd0);
        model_frames = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("wrst_s_ready", 64'(s_ready), 64'd1);
        seen = rvalid_seen;
        bnn_valid = 1'b1; tick(); bnn_valid = 1'b0;
        repeat (4) tick();
        chk("wrst_no_rvalid", 64'(rvalid_seen - seen), 64'd0);
        chk("wrst_frame_zero", 64'(r_frame), 64'd0);

`ifdef BNN_PACKER_TIMEOUT_EN
        begin
            int n;
            send_frame(0, -1, 0);
            tick();
            err_pending++;
            n = 0;
            while (!err && n < 100) begin tick(); n++; end
            chk("timeout_cycles", 64'(n), 64'(TB_TIMEOUT));
            chk("timeout_s_ready", 64'(s_ready), 64'd1);
            chk("timeout_frame", 64'(r_frame), 64'(model_frames));
            tick();
        end
`endif

        // A clean frame after everything above still completes.
        send_frame(0, -1, 5);
        bnn_respond(4'd9, 1, 1'b0);
        consume(2, 4'd9);

        repeat (3) tick();
        chk("frames_drained", 64'(q_frame.size()), 64'd0);
        chk("results_drained", 64'(q_res.size()), 64'd0);
        chk("errs_drained", 64'(err_pending), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bnn_img_packer.md
BNN_IMG_PACKER -- requirements
Module: bnn_img_packer

Interface
- REQ-001: Parameter PIX_W, 8, pixel width in bits.
- REQ-002: Parameter BIN_THR, 128, binarization threshold; pixel >= BIN_THR gives bit 1.
- REQ-003: Parameter TIMEOUT, 4096, maximum WAIT cycles; used only when BNN_PACKER_TIMEOUT_EN is defined.
- REQ-004: clk  in  1  single clock; all logic on its rising edge.
- REQ-005: rst  in  1  asynchronous, active-high reset.
- REQ-006: s_valid  in  1  pixel stream valid.
- REQ-007: s_ready  out  1  pixel stream ready.
- REQ-008: s_pixel  in  PIX_W  grayscale pixel, raster order, pixel 0 first.
- REQ-009: s_last  in  1  marks pixel 783 of a frame.
- REQ-010: m_valid  out  1  one-cycle pulse to the BNN core i_valid.
- REQ-011: m_data  out  784  packed binary image to the BNN core i_data.
- REQ-012: bnn_valid  in  1  BNN core o_valid.
- REQ-013: bnn_result  in  4  BNN core o_result, class 0..9.
- REQ-014: r_valid  out  1  classification result valid.
- REQ-015: r_ready  in  1  result consumer ready.
- REQ-016: r_result  out  4  class index.
- REQ-017: r_frame  out  16  count of frames classified, including the current one.
- REQ-018: err  out  1  one-cycle pulse on a framing error or timeout.

Function
- REQ-019: The FSM SHALL have four states: FILL, ISSUE, WAIT and RESP.
- REQ-020: A pixel SHALL transfer on s_valid && s_ready; s_ready SHALL be 1 only in FILL.
- REQ-021: In FILL, each transfer SHALL write the binarized bit of pixel index idx (0..783) into m_data[783-idx] and increment idx.
- REQ-022: On the transfer with idx==783 and s_last==1, the FSM SHALL go to ISSUE and set idx to 0.
- REQ-023: A transfer where s_last != (idx==783) SHALL pulse err for one cycle, discard the frame, clear m_data and idx to 0, and stay in FILL.
- REQ-024: ISSUE SHALL last exactly one cycle with m_valid=1 and then go to WAIT; m_valid SHALL rise the cycle after the last pixel transfer.
- REQ-025: m_data SHALL hold stable from ISSUE until the FSM returns to FILL.
- REQ-026: bnn_valid SHALL be sampled only in WAIT and ignored in every other state.
- REQ-027: On bnn_valid in WAIT, r_result SHALL capture bnn_result, r_frame SHALL increment (wrapping 0xFFFF to 0), and the FSM SHALL go to RESP.
- REQ-028: In RESP, r_valid SHALL be 1, and r_result and r_frame SHALL hold until r_valid && r_ready.
- REQ-029: After that handshake, the FSM SHALL go to FILL with m_data cleared; r_valid SHALL drop in the same cycle.
- REQ-030: Binarization SHALL be an unsigned compare of PIX_W bits; BIN_THR=0 SHALL give all ones.

Reset
- REQ-031: On rst, the FSM SHALL return to FILL and idx to 0.
- REQ-032: On rst, m_valid, m_data, r_valid, r_result, r_frame and err SHALL all be 0.
- REQ-033: s_ready SHALL be 1 in the first cycle after rst deasserts.
- REQ-034: An rst asserted mid-frame, in WAIT or in RESP SHALL discard all in-flight data; a later bnn_valid SHALL be ignored until the next WAIT.

Configuration
- REQ-035: With BNN_PACKER_TIMEOUT_EN defined, a counter SHALL start at 0 on entry to WAIT.
- REQ-036: If TIMEOUT cycles pass in WAIT without bnn_valid, the block SHALL pulse err, leave r_frame unchanged and go to FILL.
- REQ-037: Without BNN_PACKER_TIMEOUT_EN, WAIT SHALL last until bnn_valid and no counter logic SHALL exist.

Structure
- REQ-038: The shared package bnn_pkg SHALL hold N_PIX=784, N_CLASS=10, RES_W=4 and the packer state enumeration.
- REQ-039: The block SHALL be a single module with no sub-module; binarization is an inline compare.

Verification
- REQ-040: Frame of 784 pixels, even index=200, odd index=50, s_last on 783 -> m_valid pulse 1 cycle after the last pixel; m_data = {392{2'b10}}.
- REQ-041: bnn_valid with bnn_result=7 in WAIT, r_ready held 0 for 5 cycles -> r_valid=1 and r_result=7 for 5 cycles, r_frame=1; then r_ready=1 -> r_valid=0 next cycle and s_ready=1.
- REQ-042: s_last on pixel 500 -> err pulse, no m_valid; the next clean frame is issued normally.
- REQ-043: bnn_valid pulsed during FILL and during ISSUE -> no r_valid, r_frame unchanged.
- REQ-044: rst asserted in WAIT, then bnn_valid -> all outputs 0, no r_valid, s_ready=1.
- REQ-045: With BNN_PACKER_TIMEOUT_EN and TIMEOUT=16, no bnn_valid -> err pulse after 16 WAIT cycles, then FILL with r_frame unchanged.
